// File: rtl/instr_fetch_queue.sv
// Instruction prefetch FIFO with registered decode, feeding the control FSM.
// Optional ILLEGAL_OP_TRAP_EN: trap opcodes 010/011/110/111 as bubbles.
module instr_fetch_queue #(
    parameter int              DEPTH    = 2,
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    state,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_load_val,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic [2:0]    opcode,
    output logic [2:0]    rd,
    output logic [2:0]    rs1,
    output logic [2:0]    rs2,
    output logic [15:0]   imm,
    output logic          noop,
    output logic [AW-1:0] instr_pc,
    output logic          illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   fifo_data [DEPTH];
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          outstanding;
    logic          discard;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] pc_next;

    logic          fetch;
    logic          ack_take;
    logic          push;
    logic          pop;
    logic          issue;
    logic          trap;
    logic [15:0]   head;
    logic [AW-1:0] head_pc;

    assign imem_req = outstanding;
    assign fetch    = (state == 2'b00);
    assign ack_take = outstanding & imem_ack;
    assign push     = ack_take & ~discard & ~pc_load;
    assign pop      = fetch & ~pc_load & (count != '0);
    assign head     = fifo_data[rptr];
    assign head_pc  = fifo_addr[rptr];

`ifdef ILLEGAL_OP_TRAP_EN
    // Opcodes 010, 011, 110 and 111 all have bit 14 set.
    assign trap = head[14];
`else
    assign trap = 1'b0;
`endif

    // Occupancy and next fetch address after this cycle's push/pop/flush.
    always_comb begin
        count_next = count;
        pc_next    = fetch_pc;
        if (pc_load) begin
            count_next = '0;
            pc_next    = pc_load_val;
        end else begin
            if (push && !pop)
                count_next = count + CW'(1);
            else if (!push && pop)
                count_next = count - CW'(1);
            if (push)
                pc_next = fetch_pc + AW'(1);
        end
    end

    // A new request may start when the bus is free or retiring this cycle.
    assign issue = (~outstanding | ack_take) & ~pc_load
                 & (count_next < CW'(DEPTH));

    // Request tracking: one outstanding request, stale responses dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_pc    <= RESET_PC;
        end else begin
            fetch_pc <= pc_next;
            if (issue) begin
                outstanding <= 1'b1;
                imem_addr   <= pc_next;
            end else if (ack_take) begin
                outstanding <= 1'b0;
            end
            if (pc_load && outstanding && !imem_ack)
                discard <= 1'b1;
            else if (ack_take)
                discard <= 1'b0;
        end
    end

    // FIFO storage: instruction word plus the address it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= imem_rdata;
            fifo_addr[wptr] <= imem_addr;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (pc_load) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            count <= count_next;
        end
    end

    // Decode registers: load at FETCH, hold for the rest of the instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode   <= '0;
            rd       <= '0;
            rs1      <= '0;
            rs2      <= '0;
            imm      <= '0;
            noop     <= 1'b1;
            instr_pc <= '0;
            illegal  <= 1'b0;
        end else if (fetch) begin
            if (pop && !trap) begin
                opcode   <= head[15:13];
                rd       <= head[12:10];
                rs1      <= head[9:7];
                rs2      <= head[6:4];
                imm      <= {{9{head[6]}}, head[6:0]};
                noop     <= (head == 16'h0000);
                instr_pc <= head_pc;
                illegal  <= 1'b0;
            end else begin
                opcode   <= '0;
                rd       <= '0;
                rs1      <= '0;
                rs2      <= '0;
                imm      <= '0;
                noop     <= 1'b1;
                illegal  <= pop & trap;
                if (pop)
                    instr_pc <= head_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected pops and request
// addresses are queued by the stimulus and consumed by monitors.
module tb_instr_fetch_queue;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    state = 2'b11;
    logic          pc_load = 1'b0;
    logic [AW-1:0] pc_load_val = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_rdata = '0;
    logic [2:0]    opcode;
    logic [2:0]    rd;
    logic [2:0]    rs1;
    logic [2:0]    rs2;
    logic [15:0]   imm;
    logic          noop;
    logic [AW-1:0] instr_pc;
    logic          illegal;

    instr_fetch_queue #(.DEPTH(2), .AW(AW), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .state(state),
        .pc_load(pc_load), .pc_load_val(pc_load_val),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .noop(noop), .instr_pc(instr_pc),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    f_op;
        logic [2:0]    f_rd;
        logic [2:0]    f_rs1;
        logic [2:0]    f_rs2;
        logic [15:0]   f_imm;
        logic          f_noop;
        logic [AW-1:0] f_pc;
        logic          f_ill;
    } dec_t;

    int        errors = 0;
    int        checks = 0;
    bit        ack_en = 1'b1;
    logic [15:0]   mem [256];
    dec_t          exp_q [$];
    logic [AW-1:0] addr_q [$];
    dec_t          act_d;
    dec_t          exp_d;
    logic [AW-1:0] exp_a;

    function automatic dec_t e(input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic [2:0] d,
                               input logic [15:0] i, input logic n,
                               input logic [AW-1:0] p, input logic l);
        dec_t r;
        r = '{a, b, c, d, i, n, p, l};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Memory model: answers a request one cycle after it is seen.
    always @(posedge clk) begin
        #1;
        if (!rst)
            imem_ack = 1'b0;
        else if (imem_ack)
            imem_ack = 1'b0;
        else if (imem_req && ack_en) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
        end
    end

    // Decode monitor: every FETCH edge presents a new decoded instruction.
    always @(posedge clk) begin
        if (rst && state == 2'b00) begin
            #1;
            act_d = '{opcode, rd, rs1, rs2, imm, noop, instr_pc, illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop: unexpected pop got %h", act_d);
            end else begin
                exp_d = exp_q.pop_front();
                if (act_d !== exp_d) begin
                    errors++;
                    $display("FAIL pop pc=%h: got %h required %h",
                             exp_d.f_pc, act_d, exp_d);
                end
            end
        end
    end

    // Request monitor: address of every acknowledged request, in order.
    always @(negedge clk) begin
        if (rst && imem_req && imem_ack) begin
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL ack_addr: unexpected ack at %h", imem_addr);
            end else begin
                exp_a = addr_q.pop_front();
                if (imem_addr !== exp_a) begin
                    errors++;
                    $display("FAIL ack_addr: got %h required %h",
                             imem_addr, exp_a);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 16'h0000;
        mem[0]     = 16'h2A85;
        mem[1]     = 16'h0000;
        mem[2]     = 16'h907F;
        mem[3]     = 16'h8C05;
        mem[4]     = 16'h3C91;
        mem[5]     = 16'hE123;
        mem[6]     = 16'h0000;
        mem[7]     = 16'hA000;
        mem[8'h40] = 16'h1F80;

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_imm", 32'(imm), 32'h0);
        chk("rst_noop", 32'(noop), 32'h1);
        chk("rst_pc", 32'(instr_pc), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);

        for (int a = 0; a < 6; a++)
            addr_q.push_back(AW'(a));
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_req", 32'(imem_req), 32'h0);

        exp_q.push_back(e(3'd1, 3'd2, 3'd5, 3'd0, 16'h0005, 1'b0, 8'h00, 1'b0));
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h01, 1'b0));
        exp_q.push_back(e(3'd4, 3'd4, 3'd0, 3'd7, 16'hFFFF, 1'b0, 8'h02, 1'b0));
        exp_q.push_back(e(3'd4, 3'd3, 3'd0, 3'd0, 16'h0005, 1'b0, 8'h03, 1'b0));
        for (int k = 0; k < 4; k++) begin
            state = 2'b00;
            @(negedge clk);
            state = 2'b01;
            @(negedge clk);
            state = 2'b10;
            @(negedge clk);
            state = 2'b11;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("full_req_wb", 32'(imem_req), 32'h0);

        for (int a = 6; a < 10; a++)
            addr_q.push_back(AW'(a));
        exp_q.push_back(e(3'd1, 3'd7, 3'd1, 3'd1, 16'h0011, 1'b0, 8'h04, 1'b0));
`ifdef ILLEGAL_OP_TRAP_EN
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h05, 1'b1));
`else
        exp_q.push_back(e(3'd7, 3'd0, 3'd2, 3'd2, 16'h0023, 1'b0, 8'h05, 1'b0));
`endif
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h06, 1'b0));
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h06, 1'b0));
        exp_q.push_back(e(3'd5, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 8'h07, 1'b0));
        state = 2'b00;
        repeat (5) @(negedge clk);
        state = 2'b01;
        repeat (8) @(negedge clk);

        rst    = 1'b0;
        ack_en = 1'b0;
        state  = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("hold_first", {imem_req, imem_addr}, {1'b1, 8'h00});
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h00, 1'b0));
        state = 2'b00;
        @(negedge clk);
        state = 2'b01;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("hold_req", {imem_req, imem_addr}, {1'b1, 8'h00});
        end

        addr_q.push_back(8'h00);
        addr_q.push_back(8'h01);
        addr_q.push_back(8'h02);
        addr_q.push_back(8'h03);
        addr_q.push_back(8'h40);
        addr_q.push_back(8'h41);
        addr_q.push_back(8'h42);
        ack_en = 1'b1;
        repeat (8) @(negedge clk);
        exp_q.push_back(e(3'd1, 3'd2, 3'd5, 3'd0, 16'h0005, 1'b0, 8'h00, 1'b0));
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h01, 1'b0));
        state = 2'b00;
        repeat (2) @(negedge clk);
        state  = 2'b01;
        ack_en = 1'b0;
        @(negedge clk);
        exp_q.push_back(e(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1, 8'h01, 1'b0));
        state       = 2'b00;
        pc_load     = 1'b1;
        pc_load_val = 8'h40;
        @(negedge clk);
        state   = 2'b01;
        pc_load = 1'b0;
        chk("flush_hold", {imem_req, imem_addr}, {1'b1, 8'h03});
        ack_en = 1'b1;
        repeat (8) @(negedge clk);
        exp_q.push_back(e(3'd0, 3'd7, 3'd7, 3'd0, 16'h0000, 1'b0, 8'h40, 1'b0));
        state = 2'b00;
        @(negedge clk);
        state = 2'b01;
        repeat (8) @(negedge clk);

        chk("pops_left", 32'(exp_q.size()), 32'h0);
        chk("acks_left", 32'(addr_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
